des_key_schedule: RTL and testbench

Round-subkey generator sitting directly downstream of the DES control unit. It latches a 64-bit key and applies PC-1 into 28-bit C/D halves. It rotates C/D on each key_shift_en (left for encryption, right for decryption) and produces the registered 48-bit PC-2 subkey on each key_perm_en, which the round datapath's XOR stage consumes. It also tracks the round sequence internally and flags protocol violations.

---
 rtl/des_pkg.sv | 68 ++++++
 rtl/des_key_rotator.sv | 18 +
 rtl/des_key_schedule.sv | 78 +++++++
 tb/tb_des_key_schedule.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES constants and bit-permutation helpers, FIPS 46 numbering (bit 1 = MSB).
// Used by the key schedule and by the control/datapath blocks.
package des_pkg;

    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam logic [1:0] SH_TBL [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    function automatic logic [55:0] pc1(input logic [63:0] key);
        logic [55:0] r;
        for (int i = 0; i < 56; i++) r[55-i] = key[64-PC1_TBL[i]];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2_TBL[i]];
        return r;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[26:0], x[27]};
            2'd2:    return {x[25:0], x[27:26]};
            default: return x;
        endcase
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[0], x[27:1]};
            2'd2:    return {x[1:0], x[27:2]};
            default: return x;
        endcase
    endfunction

    // Each key byte must carry odd parity; flags any byte that does not.
    function automatic logic key_parity_bad(input logic [63:0] key);
        logic bad;
        bad = 1'b0;
        for (int b = 0; b < 8; b++) bad |= ~(^key[b*8 +: 8]);
        return bad;
    endfunction

endpackage

// File: rtl/des_key_rotator.sv
// Combinational 28-bit rotate by 0, 1 or 2 positions, left or right.
module des_key_rotator
    import des_pkg::*;
(
    input  logic [27:0] din,
    input  logic [1:0]  amt,
    input  logic        dir_right,
    output logic [27:0] dout
);

    // NOTE: always_comb gets a full default assignment first so no path can infer a latch.
    always_comb begin
        dout = din;
        if (dir_right) dout = rotr28(din, amt);
        else           dout = rotl28(din, amt);
    end

endmodule

// File: rtl/des_key_schedule.sv
// DES round-subkey generator: PC-1 load, per-round C/D rotation, registered PC-2 output,
// with round-sequence and key-parity checking.
module des_key_schedule
    import des_pkg::*;
#(
    parameter bit CHECK_PARITY = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_key,
    input  logic [63:0] key_in,
    input  logic        mode,
    input  logic        key_shift_en,
    input  logic        key_perm_en,
    input  logic [3:0]  round,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    output logic        schedule_done,
    output logic        seq_err,
    output logic        parity_err
);

    logic [27:0] c_r, d_r, c_next, d_next;
    logic [4:0]  shift_cnt;
    logic        mode_r;
    logic [1:0]  rot_amt;
    logic [3:0]  dec_idx;

    // Decrypt walks the table backwards; 0 - n wraps to 16 - n for n in 1..15.
    assign dec_idx = 4'd0 - shift_cnt[3:0];

    always_comb begin
        rot_amt = 2'd0;
        if (!mode_r)              rot_amt = SH_TBL[shift_cnt[3:0]];
        else if (shift_cnt != 0)  rot_amt = SH_TBL[dec_idx];
    end

    des_key_rotator u_rot_c (.din(c_r), .amt(rot_amt), .dir_right(mode_r), .dout(c_next));
    des_key_rotator u_rot_d (.din(d_r), .amt(rot_amt), .dir_right(mode_r), .dout(d_next));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_r           <= '0;
            d_r           <= '0;
            subkey        <= '0;
            shift_cnt     <= '0;
            mode_r        <= 1'b0;
            subkey_valid  <= 1'b0;
            schedule_done <= 1'b0;
            seq_err       <= 1'b0;
            parity_err    <= 1'b0;
        end else begin
            subkey_valid <= key_perm_en;
            if (key_perm_en) subkey <= pc2({c_r, d_r});

            if (load_key) begin
                {c_r, d_r}    <= pc1(key_in);
                mode_r        <= mode;
                shift_cnt     <= '0;
                seq_err       <= 1'b0;
                schedule_done <= 1'b0;
                parity_err    <= CHECK_PARITY && key_parity_bad(key_in);
            end else if (key_shift_en) begin
                if (shift_cnt < 5'd16) begin
                    c_r       <= c_next;
                    d_r       <= d_next;
                    shift_cnt <= shift_cnt + 5'd1;
                    if (shift_cnt == 5'd15)        schedule_done <= 1'b1;
                    if (round != shift_cnt[3:0])   seq_err       <= 1'b1;
                end else begin
                    seq_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule using the FIPS worked-example key.
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        reset, load_key, mode, key_shift_en, key_perm_en;
    logic [63:0] key_in;
    logic [3:0]  round;
    logic [47:0] subkey;
    logic        subkey_valid, schedule_done, seq_err, parity_err;

    des_key_schedule #(.CHECK_PARITY(1'b1)) dut (
        .clk(clk), .reset(reset), .load_key(load_key), .key_in(key_in), .mode(mode),
        .key_shift_en(key_shift_en), .key_perm_en(key_perm_en), .round(round),
        .subkey(subkey), .subkey_valid(subkey_valid), .schedule_done(schedule_done),
        .seq_err(seq_err), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_B = 64'h133457799BBCDFF0;
    localparam logic [27:0] C0    = 28'hF0CCAAF;
    localparam logic [27:0] D0    = 28'h556678F;
    localparam logic [47:0] K1    = 48'h1B02EFFC7072;
    localparam logic [47:0] K2    = 48'h79AED9DBC9E5;
    localparam logic [47:0] K15   = 48'hBF918D3D3F0A;
    localparam logic [47:0] K16   = 48'hCB3D8B0E17F5;

    typedef struct { bit dec; int rnd; logic [47:0] sk; } vec_t;
    typedef struct { bit care; logic [47:0] sk; string name; } sb_t;

    vec_t vecs [6];
    sb_t  sb [$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void lookup(input bit dec, input int r, output bit care, output logic [47:0] sk);
        care = 1'b0;
        sk   = '0;
        foreach (vecs[i]) if (vecs[i].dec == dec && vecs[i].rnd == r) begin
            care = 1'b1;
            sk   = vecs[i].sk;
        end
    endfunction

    task automatic push(input bit care, input logic [47:0] sk, input string name);
        sb_t e;
        e.care = care;
        e.sk   = sk;
        e.name = name;
        sb.push_back(e);
    endtask

    // Subkeys come out one cycle after key_perm_en; sampled mid-cycle.
    always @(negedge clk) begin
        if (subkey_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected: got subkey_valid with %h, expected none", subkey);
            end else begin
                sb_t e;
                e = sb.pop_front();
                if (e.care) check(e.name, {16'h0, subkey}, {16'h0, e.sk});
            end
        end
    end

    task automatic load(input logic [63:0] k, input logic m);
        key_in = k; mode = m; load_key = 1'b1;
        step();
        load_key = 1'b0;
    endtask

    // One control-unit round: KEY_SHIFT then KEY_PERM.
    task automatic do_round(input int r, input logic [3:0] rnd_in, input bit dec);
        bit          care;
        logic [47:0] sk;
        round = rnd_in; key_shift_en = 1'b1;
        step();
        key_shift_en = 1'b0; key_perm_en = 1'b1;
        lookup(dec, r, care, sk);
        push(care, sk, $sformatf("%s_r%0d", dec ? "dec" : "enc", r));
        step();
        key_perm_en = 1'b0;
    endtask

    task automatic run_schedule(input bit dec);
        for (int r = 0; r < 16; r++) do_round(r, 4'(r), dec);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{dec: 1'b0, rnd: 0,  sk: K1};
        vecs[1] = '{dec: 1'b0, rnd: 1,  sk: K2};
        vecs[2] = '{dec: 1'b0, rnd: 15, sk: K16};
        vecs[3] = '{dec: 1'b1, rnd: 0,  sk: K16};
        vecs[4] = '{dec: 1'b1, rnd: 1,  sk: K15};
        vecs[5] = '{dec: 1'b1, rnd: 15, sk: K1};

        reset = 1'b1; load_key = 1'b0; mode = 1'b0; key_shift_en = 1'b0;
        key_perm_en = 1'b0; key_in = '0; round = '0;
        #12;
        check("reset_outputs", {12'h0, subkey, subkey_valid, schedule_done, seq_err, parity_err}, 64'h0);
        step();
        reset = 1'b0;
        step();

        // Encrypt: load, check PC-1 halves and parity, then the full schedule.
        load(KEY_A, 1'b0);
        check("load_c0", {36'h0, dut.c_r}, {36'h0, C0});
        check("load_d0", {36'h0, dut.d_r}, {36'h0, D0});
        check("load_parity_ok", {63'h0, parity_err}, 64'h0);
        run_schedule(1'b0);
        check("enc_done", {63'h0, schedule_done}, 64'h1);
        check("enc_seq_ok", {63'h0, seq_err}, 64'h0);
        check("enc_c_wrap", {36'h0, dut.c_r}, {36'h0, C0});
        step(); step();
        check("subkey_hold", {15'h0, subkey, subkey_valid}, {15'h0, K16, 1'b0});

        // 17th shift: no rotation, sticky error; PC-2 still yields K16.
        do_round(99, 4'd0, 1'b0);
        check("shift17_seq_err", {63'h0, seq_err}, 64'h1);
        check("shift17_c_hold", {36'h0, dut.c_r}, {36'h0, C0});
        push(1'b1, K16, "perm_after_shift17");
        key_perm_en = 1'b1; step(); key_perm_en = 1'b0;
        step();

        // Decrypt: load clears seq_err, subkeys come out in reverse order.
        load(KEY_A, 1'b1);
        check("dec_load_seq_clr", {63'h0, seq_err}, 64'h0);
        run_schedule(1'b1);
        check("dec_done", {63'h0, schedule_done}, 64'h1);
        check("dec_seq_ok", {63'h0, seq_err}, 64'h0);

        // Round mismatch at shift_cnt 3.
        load(KEY_A, 1'b0);
        for (int r = 0; r < 3; r++) do_round(r, 4'(r), 1'b0);
        check("pre_mismatch_seq", {63'h0, seq_err}, 64'h0);
        do_round(3, 4'd5, 1'b0);
        check("mismatch_seq_err", {63'h0, seq_err}, 64'h1);

        // load_key with key_shift_en: load wins, bad-parity key.
        key_in = KEY_B; mode = 1'b0; load_key = 1'b1; key_shift_en = 1'b1; round = 4'd9;
        step();
        load_key = 1'b0; key_shift_en = 1'b0;
        check("ldshift_cnt", {59'h0, dut.shift_cnt}, 64'h0);
        check("ldshift_c", {36'h0, dut.c_r}, {36'h0, C0});
        check("ldshift_d", {36'h0, dut.d_r}, {36'h0, D0});
        check("ldshift_seq_clr", {63'h0, seq_err}, 64'h0);
        check("ldshift_parity", {63'h0, parity_err}, 64'h1);

        // load_key with key_perm_en: subkey from the pre-load C1/D1.
        load(KEY_A, 1'b0);
        do_round(0, 4'd0, 1'b0);
        push(1'b1, K1, "perm_with_load");
        key_in = KEY_A; mode = 1'b0; load_key = 1'b1; key_perm_en = 1'b1;
        step();
        load_key = 1'b0; key_perm_en = 1'b0;
        check("ldperm_c_reload", {36'h0, dut.c_r}, {36'h0, C0});
        step();

        // Asynchronous reset after 7 shifts with errors pending.
        load(KEY_B, 1'b0);
        for (int r = 0; r < 7; r++) do_round(r, (r == 3) ? 4'd8 : 4'(r), 1'b0);
        step();
        check("pre_reset_flags", {62'h0, seq_err, parity_err}, 64'h3);
        #2 reset = 1'b1;
        #1;
        check("async_reset_outputs", {12'h0, subkey, subkey_valid, schedule_done, seq_err, parity_err}, 64'h0);
        check("async_reset_cnt", {59'h0, dut.shift_cnt}, 64'h0);
        step();
        reset = 1'b0;
        step();
        load(KEY_A, 1'b0);
        run_schedule(1'b0);
        check("rerun_done", {62'h0, schedule_done, seq_err}, 64'h2);

        step(); step();
        check("sb_drained", 64'(sb.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
